// File: rtl/tl_sensor_pkg.sv
// -----------------------------------------------------------------------------
// tl_sensor_pkg
// Shared definitions for the traffic-light sensor conditioner and controller:
//   - sens_state_e : per-channel sensor FSM encodings (IDLE/QUAL/ACTIVE/HOLD)
//   - COLOR_*      : traffic-colour constants shared with tl_cntr
//   - max_u()      : elaboration-time helper for sizing counter limits
// -----------------------------------------------------------------------------
package tl_sensor_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_QUAL   = 2'b01,
        S_ACTIVE = 2'b10,
        S_HOLD   = 2'b11
    } sens_state_e;

    localparam logic [1:0] COLOR_GREEN  = 2'b00;
    localparam logic [1:0] COLOR_YELLOW = 2'b01;
    localparam logic [1:0] COLOR_RED    = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_sensor_ch.sv
// -----------------------------------------------------------------------------
// tl_sensor_ch
// One detector channel: 2-flop synchronizer, debounce/hold FSM and counter.
// Optional feature macro: TL_SENSOR_HOLD_EN (builds the HOLD gap-stretch state).
//
// Ports:
//   clk     in  : block clock
//   reset_n in  : asynchronous active-low reset
//   raw     in  : raw detector input, asynchronous to clk
//   t       out : registered conditioned traffic-present flag
// -----------------------------------------------------------------------------
module tl_sensor_ch
    import tl_sensor_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic t
);

    // Comparing against N-1 instead of cnt+1==N keeps the test inside CNT_W bits.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`ifdef TL_SENSOR_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`endif
    // Highest count either phase can reach; the increment saturates here so
    // the counter can never wrap even if the state were corrupted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_u(DEB_CYCLES, HOLD_CYCLES) - 1);

    logic              r_sync1;
    logic              r_sync2;
    sens_state_e       r_state;
    sens_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_t;
    logic              w_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, as the synchronizer requires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s       = r_sync2;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // NOTE: next-state and next-count get defaults before the case so no
    // path leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_s) begin
                    if (DEB_CYCLES == 1) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_QUAL;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_QUAL: begin
                if (!w_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_ACTIVE: begin
                if (!w_s) begin
`ifdef TL_SENSOR_HOLD_EN
                    if (HOLD_CYCLES == 1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = CNT_W'(1);
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
`endif
                end
            end
`ifdef TL_SENSOR_HOLD_EN
            S_HOLD: begin
                if (w_s) begin
                    // Any high sample cancels the gap; the hold count restarts
                    // from scratch at the next low.
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
`endif
            default: begin
                // Encodings not built in this configuration fall back to IDLE.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_t     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // T is registered from the next state so it tracks r_state exactly.
            r_t     <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_HOLD);
        end
    end

    assign t = r_t;

endmodule

// File: rtl/tl_sensor.sv
// -----------------------------------------------------------------------------
// tl_sensor
// Conditions the two raw vehicle detectors into the clean Ta/Tb traffic-present
// signals consumed by tl_cntr. Two identical, fully independent channels.
// Optional feature macro: TL_SENSOR_HOLD_EN (gap-stretch hold on each channel).
//
// Ports:
//   clk     in  : block clock
//   reset_n in  : asynchronous active-low reset
//   sa_raw  in  : street-A detector, asynchronous, active-high
//   sb_raw  in  : street-B detector, asynchronous, active-high
//   Ta      out : registered conditioned street-A traffic present
//   Tb      out : registered conditioned street-B traffic present
// -----------------------------------------------------------------------------
module tl_sensor #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Ta,
    output logic Tb
);

    tl_sensor_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ch_a (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sa_raw),
        .t       (Ta)
    );

    tl_sensor_ch #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ch_b (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sb_raw),
        .t       (Tb)
    );

endmodule
